// File: rtl/spi_frame_sequencer_pkg.sv
// Shared definitions for the pluto SPI frame sequencer: FSM states, slot map
// and default frame geometry.
package pluto_spi_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_NSLOT  = 5;
    localparam int DEF_SLOT_W = 3;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        LOAD,
        SHIFT
    } seq_state_t;

    // Read side: snapshots fetched for MISO
    localparam logic [DEF_SLOT_W-1:0] SLOT_QUAD0  = 3'd0;
    localparam logic [DEF_SLOT_W-1:0] SLOT_QUAD1  = 3'd1;
    localparam logic [DEF_SLOT_W-1:0] SLOT_QUAD2  = 3'd2;
    localparam logic [DEF_SLOT_W-1:0] SLOT_QUAD3  = 3'd3;
    localparam logic [DEF_SLOT_W-1:0] SLOT_INPUTS = 3'd4;

    // Write side: destinations of received MOSI words
    localparam logic [DEF_SLOT_W-1:0] SLOT_PWM0 = 3'd0;
    localparam logic [DEF_SLOT_W-1:0] SLOT_PWM1 = 3'd1;
    localparam logic [DEF_SLOT_W-1:0] SLOT_PWM2 = 3'd2;
    localparam logic [DEF_SLOT_W-1:0] SLOT_PWM3 = 3'd3;
    localparam logic [DEF_SLOT_W-1:0] SLOT_DOUT = 3'd4;

endpackage

// File: rtl/spi_frame_sequencer_if.sv
// Datapath-side bus of the frame sequencer: slot read fetch, word write strobe
// and frame status pulses.
interface spi_frame_sequencer_if #(
    parameter int WORD_W = 32,
    parameter int SLOT_W = 3
);
    logic              rd_req;
    logic [SLOT_W-1:0] rd_slot;
    logic [WORD_W-1:0] rd_data;
    logic              wr_stb;
    logic [SLOT_W-1:0] wr_slot;
    logic [WORD_W-1:0] wr_data;
    logic              frame_active;
    logic              frame_done;
    logic              frame_err;

    modport master (
        output rd_req, rd_slot, wr_stb, wr_slot, wr_data,
        output frame_active, frame_done, frame_err,
        input  rd_data
    );

    modport slave (
        input  rd_req, rd_slot, wr_stb, wr_slot, wr_data,
        input  frame_active, frame_done, frame_err,
        output rd_data
    );
endinterface

// File: rtl/spi_frame_sequencer_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with a third stage for
// single-cycle rise/fall pulses. Resets to the pin's idle level.
module sync_edge #(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] pipe_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_reg <= {3{IDLE_LVL}};
        end else begin
            pipe_reg <= {pipe_reg[1:0], din};
        end
    end

    assign level = pipe_reg[1];
    assign rise  = pipe_reg[1] & ~pipe_reg[2];
    assign fall  = ~pipe_reg[1] & pipe_reg[2];
endmodule

// File: rtl/spi_frame_sequencer.sv
// SPI-slave frame sequencer: oversamples the SPI pins in clk, shifts fixed
// NSLOT-word frames and issues slot read fetches and word write strobes.
module spi_frame_sequencer
    import pluto_spi_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int NSLOT  = DEF_NSLOT,
    parameter int SLOT_W = DEF_SLOT_W
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   spi_sclk,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    spi_frame_sequencer_if.master  bus
);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [2:0] SYNC_IDLE = 3'b010;   // {mosi, cs_n, sclk}

    logic [2:0] pin_vec, level_vec, rise_vec, fall_vec;
    assign pin_vec = {spi_mosi, spi_cs_n, spi_sclk};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            sync_edge #(.IDLE_LVL(SYNC_IDLE[gi])) u_sync (
                .clk   (clk),
                .rst_n (nReset),
                .din   (pin_vec[gi]),
                .level (level_vec[gi]),
                .rise  (rise_vec[gi]),
                .fall  (fall_vec[gi])
            );
        end
    endgenerate

    logic sclk_rise, sclk_fall, cs_level, cs_rise, cs_fall, mosi_level;
    assign sclk_rise  = rise_vec[0];
    assign sclk_fall  = fall_vec[0];
    assign cs_level   = level_vec[1];
    assign cs_rise    = rise_vec[1];
    assign cs_fall    = fall_vec[1];
    assign mosi_level = level_vec[2];

    // mosi edges and the sclk level carry no information here
    logic unused_sync;
    assign unused_sync = ^{level_vec[0], rise_vec[2], fall_vec[2]};

    seq_state_t        state_reg, state_next;
    logic [SLOT_W-1:0] slot_reg, slot_next, slot_upd;
    logic [CNT_W-1:0]  bitcnt_reg, bitcnt_next, bitcnt_upd;
    logic [WORD_W-1:0] tx_shift_reg, tx_shift_next;
    logic [WORD_W-1:0] rx_shift_reg, rx_shift_next;
    logic [1:0]        settle_reg, settle_next;
    logic              wr_stb_reg, wr_stb_next;
    logic [SLOT_W-1:0] wr_slot_reg, wr_slot_next;
    logic [WORD_W-1:0] wr_data_reg, wr_data_next;
    logic              active_reg, active_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              rd_req;
    logic [SLOT_W-1:0] rd_slot;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg    <= WAIT_IDLE;
            slot_reg     <= '0;
            bitcnt_reg   <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            settle_reg   <= '0;
            wr_stb_reg   <= 1'b0;
            wr_slot_reg  <= '0;
            wr_data_reg  <= '0;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            slot_reg     <= slot_next;
            bitcnt_reg   <= bitcnt_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            settle_reg   <= settle_next;
            wr_stb_reg   <= wr_stb_next;
            wr_slot_reg  <= wr_slot_next;
            wr_data_reg  <= wr_data_next;
            active_reg   <= active_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        slot_next     = slot_reg;
        bitcnt_next   = bitcnt_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        settle_next   = settle_reg;
        wr_stb_next   = 1'b0;
        wr_slot_next  = wr_slot_reg;
        wr_data_next  = wr_data_reg;
        active_next   = active_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        rd_req        = 1'b0;
        rd_slot       = slot_reg;
        slot_upd      = slot_reg;
        bitcnt_upd    = bitcnt_reg;

        case (state_reg)
            WAIT_IDLE: begin
                // cs_n must stay high long enough to flush the synchronizers,
                // otherwise a reset released mid-frame would see a fake CS fall
                if (!cs_level) begin
                    settle_next = '0;
                end else if (settle_reg == 2'd3) begin
                    settle_next = '0;
                    state_next  = IDLE;
                end else begin
                    settle_next = settle_reg + 2'd1;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    rd_req      = 1'b1;
                    rd_slot     = '0;
                    slot_next   = '0;
                    bitcnt_next = '0;
                    active_next = 1'b1;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                tx_shift_next = bus.rd_data;
                bitcnt_next   = '0;
                state_next    = SHIFT;
            end
            SHIFT: begin
                if (bitcnt_reg == CNT_W'(WORD_W)) begin
                    if (slot_reg < SLOT_W'(NSLOT)) begin
                        wr_stb_next  = 1'b1;
                        wr_slot_next = slot_reg;
                        wr_data_next = rx_shift_reg;
                        slot_upd     = slot_reg + 1'b1;
                    end
                    bitcnt_upd  = '0;
                    slot_next   = slot_upd;
                    bitcnt_next = '0;
                    if (slot_upd < SLOT_W'(NSLOT) && !cs_rise) begin
                        rd_req     = 1'b1;
                        rd_slot    = slot_upd;
                        state_next = LOAD;
                    end else begin
                        tx_shift_next = '0;
                    end
                end else if (sclk_rise) begin
                    rx_shift_next = {rx_shift_reg[WORD_W-2:0], mosi_level};
                    bitcnt_next   = bitcnt_reg + 1'b1;
                end else if (sclk_fall && bitcnt_reg != '0) begin
                    tx_shift_next = {tx_shift_reg[WORD_W-2:0], 1'b0};
                end
            end
            default: state_next = WAIT_IDLE;
        endcase

        if ((state_reg == LOAD || state_reg == SHIFT) && cs_rise) begin
            active_next = 1'b0;
            state_next  = IDLE;
            slot_next   = '0;
            bitcnt_next = '0;
            if (bitcnt_upd == '0 && slot_upd >= SLOT_W'(NSLOT)) begin
                done_next = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    assign spi_miso         = tx_shift_reg[WORD_W-1];
    assign bus.rd_req       = rd_req;
    assign bus.rd_slot      = rd_slot;
    assign bus.wr_stb       = wr_stb_reg;
    assign bus.wr_slot      = wr_slot_reg;
    assign bus.wr_data      = wr_data_reg;
    assign bus.frame_active = active_reg;
    assign bus.frame_done   = done_reg;
    assign bus.frame_err    = err_reg;
endmodule

// File: doc/spi_frame_sequencer.md
Name: spi_frame_sequencer

Overview:
- SPI-slave transaction sequencer for the RaspberryPi pluto servo firmware; it takes the place of the EPP strobe/address-increment logic.
- Each chip-select frame is a fixed sequence of NSLOT full-duplex words. Slot N reads the snapshot for slot N (quad0..3, raw inputs) and writes word N (pwm0..3, dout/config).
- The block generates the read-latch and write-strobe pulses that sequence the existing PWM, quadrature and watchdog datapath.
- All SPI pins are oversampled in the clk domain; there is no second clock.

Parameters:
- WORD_W, 32: bits per word, shifted MSB first.
- NSLOT, 5: words per frame.
- SLOT_W, 3: width of slot index; must satisfy 2**SLOT_W > NSLOT.

Ports:
- clk  in  1  system clock, 40 MHz.
- nReset  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock, mode 0, asynchronous.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  serial data in.
- spi_miso  out  1  serial data out; always driven, no tristate.
- rd_req  out  1  one-cycle pulse; latch/clear source rd_slot (qrN equivalent).
- rd_slot  out  SLOT_W  slot being fetched.
- rd_data  in  WORD_W  snapshot of rd_slot, valid the cycle after rd_req.
- wr_stb  out  1  one-cycle pulse; wr_data complete for wr_slot.
- wr_slot  out  SLOT_W  slot of received word.
- wr_data  out  WORD_W  received word.
- frame_active  out  1  high from CS-fall detect to CS-rise detect.
- frame_done  out  1  pulse; frame ended cleanly with at least NSLOT words.
- frame_err  out  1  pulse; frame ended mid-word or with fewer than NSLOT words.

Behaviour:
- Sub-module sync_edge: sclk, cs_n and mosi pass through 2-FF synchronizers. Rise/fall pulses come from a third stage.
- Latency from SPI pin to detect is 3 clk.
- Timing requirement: sclk high and low ≥ 4 clk each; cs_n setup/hold to sclk ≥ 4 clk.
- Reset values: all outputs 0, spi_miso 0, state WAIT_IDLE, slot 0, bitcnt 0, shift registers 0.
- State WAIT_IDLE: leave for IDLE only when synced cs_n = 1. A reset released mid-frame therefore ignores the rest of that frame.
- State IDLE, on cs fall:
  - pulse rd_req with rd_slot = 0;
  - frame_active <= 1;
  - go to LOAD.
- State LOAD (1 cycle): tx_shift <= rd_data; bitcnt <= 0; go to SHIFT. spi_miso = tx_shift[WORD_W-1] at all times.
- State SHIFT, on sclk rise:
  - rx_shift <= {rx_shift, mosi_sync};
  - bitcnt++.
- State SHIFT, on sclk fall: tx_shift <<= 1, but only when 0 < bitcnt < WORD_W.
- Word complete, on the sclk rise that makes bitcnt = WORD_W:
  - next cycle, if slot < NSLOT: pulse wr_stb, wr_slot = slot, wr_data = received word.
  - then slot++ (saturating at NSLOT) and bitcnt <= 0.
  - if the new slot < NSLOT: pulse rd_req(rd_slot = new slot), go to LOAD.
  - otherwise: tx_shift <= 0 and stay in SHIFT.
  - the next word's MSB is valid ≥ 2 clk before the following sclk fall.
- Overrun: words beyond NSLOT are clocked normally, read as 0, and produce no wr_stb.
- On cs rise from any frame state:
  - frame_active <= 0; go to IDLE.
  - frame_done pulses if bitcnt = 0 and slot ≥ NSLOT; otherwise frame_err pulses.
  - a partial word never produces wr_stb.
  - slot and bitcnt are cleared.
- CS rising in the same cycle as word completion: the complete word's wr_stb still fires (one cycle later), and frame_done is evaluated with the updated slot.
- rd_req and wr_stb never fire while cs_n is high, while in WAIT_IDLE, or during reset.
- sclk edges seen while cs_n is high are ignored.

Decomposition:
- Shared package pluto_spi_pkg holds:
  - state enum {WAIT_IDLE, IDLE, LOAD, SHIFT};
  - slot constants SLOT_QUAD0..3 = 0..3 and SLOT_INPUTS = 4 (read side);
  - SLOT_PWM0..3 = 0..3 and SLOT_DOUT = 4 (write side);
  - WORD_W and NSLOT defaults.
- One sub-module, sync_edge: 2-FF synchronizer plus rise/fall detect, instantiated 3×, with an asynchronous active-low reset to the idle level (sclk 0, cs_n 1, mosi 0).

Test Plan:
- Normal frame: rd_data model returns 32'hA5000000+slot; host sends 5 words 32'h00001000..32'h00001004.
  - MISO bits equal A5000000..A5000004.
  - wr_stb fires 5×, with slots 0..4 carrying the sent words.
  - rd_req fires 5×; frame_done fires once; frame_err never fires.
- Short frame: cs rises after 2 words plus 7 bits → exactly 2 wr_stb (slots 0,1), frame_err = 1, frame_done = 0.
- Overrun: 7 words sent → 5 wr_stb; words 6–7 read 32'h0; frame_done = 1.
- Reset mid-frame: nReset pulsed low after 40 bits with cs_n held low.
  - During reset all outputs are 0.
  - Remaining sclk edges cause no rd_req or wr_stb.
  - After cs_n rises, the next full frame completes normally.
- Edge timing: sclk at clk/8 and at the minimum clk/8 with 4/4 duty, plus random jitter → bit-exact MOSI/MISO across 1000 frames.
- Idle noise: sclk toggles with cs_n high → no rd_req, wr_stb or frame pulses; spi_miso stays at its last value.
